// File: rtl/ysyx_25020032_axi_rd_arbiter_pkg.sv
// Shared AXI read-arbiter constants, state encodings and grant modes.
// Round-robin arbitration is selected by defining ARB_RR_EN.
package ysyx_25020032_axi_rd_arbiter_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;

  localparam logic [7:0] AXI_LEN_DEF   = 8'd0;
  localparam logic [2:0] AXI_SIZE_DEF  = 3'b010;
  localparam logic [1:0] AXI_BURST_INC = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ysyx_25020032_arb_pick.sv
// Combinational 2-way picker: index of the winning requester.
// mode=0 favours req[1]; mode=1 gives a tie to the one not granted last.
module ysyx_25020032_arb_pick
  import ysyx_25020032_axi_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       mode,
  output logic       gnt
);

  logic tie;

  assign tie = &req;

  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      tie: begin
        gnt = (mode == ARB_RR) ? ~last_gnt : 1'b1;
      end
      (req == 2'b10): gnt = 1'b1;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_25020032_axi_rd_arbiter.sv
// Shares one AXI4 read master between IFU (m0) and LSU (m1).
// Define ARB_RR_EN for round-robin ties; default is fixed m1 > m0.
module ysyx_25020032_axi_rd_arbiter
  import ysyx_25020032_axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int ID_W   = AXI_ID_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic [ID_W-1:0]   m0_rid,

  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic [ID_W-1:0]   m1_rid,

  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [ID_W-1:0]   s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [ID_W-1:0]   s_rid
);

  arb_state_e state_q, state_d;
  logic       gnt_q;
  logic       pick;
  logic       grant_en;
  logic       last_gnt;
  logic       mode;
  logic       r_hs;

`ifdef ARB_RR_EN
  logic last_gnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
    end else if (grant_en) begin
      last_gnt_q <= pick;
    end
  end

  assign last_gnt = last_gnt_q;
  assign mode     = ARB_RR;
`else
  assign last_gnt = 1'b1;
  assign mode     = ARB_FIXED;
`endif

  ysyx_25020032_arb_pick u_pick (
    .req      ({m1_arvalid, m0_arvalid}),
    .last_gnt (last_gnt),
    .mode     (mode),
    .gnt      (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        gnt_q <= pick;
      end
    end
  end

  // Only the granted side's ready can complete a beat.
  assign r_hs = s_rvalid & s_rlast &
                (gnt_q ? m1_rready : m0_rready);

  always_comb begin
    state_d    = state_q;
    grant_en   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    m0_rresp   = 2'b00;
    m1_rresp   = 2'b00;
    m0_rlast   = 1'b0;
    m1_rlast   = 1'b0;
    m0_rid     = '0;
    m1_rid     = '0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = 8'd0;
    s_arsize   = 3'd0;
    s_arburst  = 2'd0;
    s_rready   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          grant_en = 1'b1;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        s_arvalid = 1'b1;
        if (gnt_q) begin
          s_araddr   = m1_araddr;
          s_arid     = m1_arid;
          s_arlen    = m1_arlen;
          s_arsize   = m1_arsize;
          s_arburst  = m1_arburst;
          m1_arready = s_arready;
        end else begin
          s_araddr   = m0_araddr;
          s_arid     = m0_arid;
          s_arlen    = m0_arlen;
          s_arsize   = m0_arsize;
          s_arburst  = m0_arburst;
          m0_arready = s_arready;
        end
        if (s_arready) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (gnt_q) begin
          s_rready  = m1_rready;
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rlast  = s_rlast;
          m1_rid    = s_rid;
        end else begin
          s_rready  = m0_rready;
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rlast  = s_rlast;
          m0_rid    = s_rid;
        end
        if (r_hs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25020032_axi_rd_arbiter.sv
// Directed bench for the IFU/LSU AXI read arbiter.
// Expectations follow ARB_RR_EN when the design is built with it.
module tb_ysyx_25020032_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_arvalid, m0_arready;
  logic [31:0] m0_araddr;
  logic [3:0]  m0_arid;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst;
  logic        m0_rvalid, m0_rready;
  logic [31:0] m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m0_rlast;
  logic [3:0]  m0_rid;
  logic        m1_arvalid, m1_arready;
  logic [31:0] m1_araddr;
  logic [3:0]  m1_arid;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst;
  logic        m1_rvalid, m1_rready;
  logic [31:0] m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_rlast;
  logic [3:0]  m1_rid;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [3:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [3:0]  s_rid;

  int n_cmp = 0;
  int n_bad = 0;
  logic w;

  always #5 clk = ~clk;

  ysyx_25020032_axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_araddr(m0_araddr), .m0_arid(m0_arid),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_araddr(m1_araddr), .m1_arid(m1_arid),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic who,
                            input logic [31:0] a);
    chk("s_arvalid", {31'd0, s_arvalid}, 1);
    chk("s_araddr", s_araddr, a);
    s_arready = 1'b1;
    #1;
    chk("arready_win",
        {31'd0, who ? m1_arready : m0_arready}, 1);
    chk("arready_lose",
        {31'd0, who ? m0_arready : m1_arready}, 0);
    tick();
    s_arready = 1'b0;
    if (who) m1_arvalid = 1'b0;
    else     m0_arvalid = 1'b0;
  endtask

  task automatic beat(input logic who,
                      input logic [31:0] d,
                      input logic [1:0] resp,
                      input logic last,
                      input logic rdy);
    s_rvalid = 1'b1;
    s_rdata  = d;
    s_rresp  = resp;
    s_rlast  = last;
    s_rid    = 4'h5;
    if (who) m1_rready = rdy;
    else     m0_rready = rdy;
    #1;
    chk("rvalid_win",
        {31'd0, who ? m1_rvalid : m0_rvalid}, 1);
    chk("rvalid_lose",
        {31'd0, who ? m0_rvalid : m1_rvalid}, 0);
    chk("rdata", who ? m1_rdata : m0_rdata, d);
    chk("rresp", {30'd0, who ? m1_rresp : m0_rresp},
        {30'd0, resp});
    chk("rlast", {31'd0, who ? m1_rlast : m0_rlast},
        {31'd0, last});
    chk("rid", {28'd0, who ? m1_rid : m0_rid}, 32'h5);
    chk("s_rready", {31'd0, s_rready}, {31'd0, rdy});
    tick();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0_arvalid = 0; m0_araddr = 0; m0_arid = 4'h1;
    m0_arlen = 0; m0_arsize = 3'b010; m0_arburst = 2'b01;
    m0_rready = 0;
    m1_arvalid = 0; m1_araddr = 0; m1_arid = 4'h2;
    m1_arlen = 0; m1_arsize = 3'b010; m1_arburst = 2'b01;
    m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0;
    s_rresp = 0; s_rlast = 0; s_rid = 0;
    tick();
    tick();
    chk("rst_m0_arready", {31'd0, m0_arready}, 0);
    chk("rst_m1_arready", {31'd0, m1_arready}, 0);
    chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 0);
    chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 0);
    chk("rst_s_arvalid", {31'd0, s_arvalid}, 0);
    chk("rst_s_rready", {31'd0, s_rready}, 0);
    rst = 1'b0;

    // m0 alone, slave accepts address two cycles late
    m0_arvalid = 1; m0_araddr = 32'h8000_0000;
    #1;
    chk("idle_no_arvalid", {31'd0, s_arvalid}, 0);
    tick();
    chk("grant_lat_arvalid", {31'd0, s_arvalid}, 1);
    chk("s_arid_m0", {28'd0, s_arid}, 32'h1);
    chk("wait_m0_arready", {31'd0, m0_arready}, 0);
    tick();
    chk("wait2_m0_arready", {31'd0, m0_arready}, 0);
    addr_phase(0, 32'h8000_0000);
    beat(0, 32'h0000_0413, 2'd0, 1, 1);
    chk("back_idle_rready", {31'd0, s_rready}, 0);
    chk("back_idle_arvalid", {31'd0, s_arvalid}, 0);

    // simultaneous requests: m1 wins in both modes here
    m0_arvalid = 1; m0_araddr = 32'h8000_0004;
    m1_arvalid = 1; m1_araddr = 32'ha000_0048;
    tick();
    chk("tie_s_arid", {28'd0, s_arid}, 32'h2);
    addr_phase(1, 32'ha000_0048);
    #1;
    chk("pend_m0_arready", {31'd0, m0_arready}, 0);
    beat(1, 32'hdead_beef, 2'd0, 1, 1);
    tick();
    addr_phase(0, 32'h8000_0004);
    beat(0, 32'h0000_1111, 2'd0, 1, 1);

    // m1 burst of four with rready toggling
    m1_arvalid = 1; m1_araddr = 32'h9000_0000;
    m1_arlen = 8'd3;
    tick();
    chk("burst_s_arlen", {24'd0, s_arlen}, 32'h3);
    addr_phase(1, 32'h9000_0000);
    m1_arlen = 8'd0;
    beat(1, 32'h11, 2'd0, 0, 0);
    beat(1, 32'h11, 2'd0, 0, 1);
    beat(1, 32'h22, 2'd0, 0, 1);
    beat(1, 32'h33, 2'd0, 0, 0);
    beat(1, 32'h33, 2'd0, 0, 1);
    beat(1, 32'h44, 2'd0, 1, 0);
    beat(1, 32'h44, 2'd0, 1, 1);
    chk("burst_idle_rready", {31'd0, s_rready}, 0);

    // second tie right after an m1 grant
`ifdef ARB_RR_EN
    w = 1'b0;
`else
    w = 1'b1;
`endif
    m0_arvalid = 1; m0_araddr = 32'h8000_0010;
    m1_arvalid = 1; m1_araddr = 32'ha000_0010;
    tick();
    addr_phase(w, w ? 32'ha000_0010 : 32'h8000_0010);
    beat(w, 32'h0000_2222, 2'd0, 1, 1);
    tick();
    addr_phase(~w, w ? 32'h8000_0010 : 32'ha000_0010);
    beat(~w, 32'h0000_3333, 2'd0, 1, 1);

    // DECERR for m1, with m0 pending behind it
    m1_arvalid = 1; m1_araddr = 32'h0000_0000;
    tick();
    m0_arvalid = 1; m0_araddr = 32'h8000_0020;
    #1;
    chk("busy_m0_arready", {31'd0, m0_arready}, 0);
    addr_phase(1, 32'h0000_0000);
    beat(1, 32'h0, 2'd3, 1, 1);
    tick();
    addr_phase(0, 32'h8000_0020);

    // m1 raised while m0 is in data phase
    m1_arvalid = 1; m1_araddr = 32'ha000_0080;
    #1;
    chk("data_m1_arready", {31'd0, m1_arready}, 0);
    chk("data_s_arvalid", {31'd0, s_arvalid}, 0);
    beat(0, 32'h0000_0055, 2'd0, 1, 1);
    chk("post_m1_arready", {31'd0, m1_arready}, 0);
    tick();
    addr_phase(1, 32'ha000_0080);
    beat(1, 32'h0000_0066, 2'd0, 1, 1);

    // reset abandons a transaction in data phase
    m0_arvalid = 1; m0_araddr = 32'h8000_0030;
    tick();
    addr_phase(0, 32'h8000_0030);
    s_rvalid = 1; m0_rready = 1;
    #1;
    chk("pre_rst_m0_rvalid", {31'd0, m0_rvalid}, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_m0_rvalid", {31'd0, m0_rvalid}, 0);
    chk("mid_rst_s_rready", {31'd0, s_rready}, 0);
    chk("mid_rst_s_arvalid", {31'd0, s_arvalid}, 0);
    chk("mid_rst_m0_arready", {31'd0, m0_arready}, 0);
    chk("mid_rst_m1_arready", {31'd0, m1_arready}, 0);
    chk("mid_rst_m1_rvalid", {31'd0, m1_rvalid}, 0);
    rst = 1'b0;
    s_rvalid = 0;
    m0_arvalid = 1; m0_araddr = 32'h8000_0040;
    tick();
    addr_phase(0, 32'h8000_0040);
    beat(0, 32'h0000_0077, 2'd0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
